// File: rtl/dist_wr_gen_pkg.sv
// rtl/dist_wr_gen_pkg.sv - state encoding for the write-request generator
package dist_wr_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/lynxTypes.sv
// rtl/lynxTypes.sv - shared address/process/length widths
package lynxTypes;
  localparam int VADDR_BITS = 48;
  localparam int PID_BITS   = 6;
  localparam int LEN_BITS   = 28;
endpackage

// File: rtl/dist_wr_gen_if.sv
// rtl/dist_wr_gen_if.sv - input stream, write request and write data bundle
interface dist_wr_gen_if #(
  parameter int DATA_BITS = 512
);
  import lynxTypes::*;
  localparam int BEAT_BYTES = DATA_BITS / 8;

  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_BITS-1:0]  s_tdata;
  logic [BEAT_BYTES-1:0] s_tkeep;
  logic                  s_tlast;

  logic                  m_req_valid;
  logic                  m_req_ready;
  logic [VADDR_BITS-1:0] m_req_vaddr;
  logic [LEN_BITS-1:0]   m_req_len;
  logic [PID_BITS-1:0]   m_req_pid;
  logic                  m_req_last;

  logic                  m_tvalid;
  logic                  m_tready;
  logic [DATA_BITS-1:0]  m_tdata;
  logic [BEAT_BYTES-1:0] m_tkeep;
  logic                  m_tlast;

  // generator side: consumes the join stream, produces request and data
  modport master (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_req_ready, m_tready,
    output s_tready, m_req_valid, m_req_vaddr, m_req_len, m_req_pid, m_req_last,
    output m_tvalid, m_tdata, m_tkeep, m_tlast
  );

  // environment side
  modport slave (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, m_req_ready, m_tready,
    input  s_tready, m_req_valid, m_req_vaddr, m_req_len, m_req_pid, m_req_last,
    input  m_tvalid, m_tdata, m_tkeep, m_tlast
  );
endinterface

// File: rtl/dist_wr_fifo.sv
// rtl/dist_wr_fifo.sv - synchronous chunk buffer with full/empty flags
module dist_wr_fifo #(
  parameter int WIDTH = 576,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // head of the queue is visible combinationally so a read can happen every cycle
  assign rd_data = mem[rd_ptr];

  // storage array; contents are simply abandoned on reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap explicitly so DEPTH need not be a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dist_wr_gen.sv
// rtl/dist_wr_gen.sv - chops the join stream into chunked write requests plus data
module dist_wr_gen
  import lynxTypes::*;
  import dist_wr_gen_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int MAX_BEATS = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [VADDR_BITS-1:0] vaddr,
  input  logic [PID_BITS-1:0]   pid,
  input  logic                  restart,
  dist_wr_gen_if.master         bus,
  output logic                  busy
);
  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);
  localparam int BYTE_W     = $clog2(MAX_BEATS * BEAT_BYTES + 1);
  localparam int FW         = DATA_BITS + BEAT_BYTES;

  state_t                state;
  logic [VADDR_BITS-1:0] ptr;
  logic [PID_BITS-1:0]   pid_q;
  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]      out_cnt;
  logic [BYTE_W-1:0]     byte_cnt;
  logic [BYTE_W-1:0]     keep_cnt;
  logic                  last_q;
  logic                  req_valid_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_dout;
  logic                  in_fire;
  logic                  out_fire;
  logic                  out_last;
  logic                  chunk_end;

  // popcount of the accepted beat's byte enables
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < BEAT_BYTES; i++) keep_cnt = keep_cnt + BYTE_W'(bus.s_tkeep[i]);
  end

  assign bus.s_tready = (state == ST_FILL) && !fifo_full;
  assign in_fire      = bus.s_tvalid && bus.s_tready;
  assign chunk_end    = in_fire && (bus.s_tlast || (beat_cnt == CNT_W'(MAX_BEATS - 1)));

  assign bus.m_tvalid = (state == ST_DRAIN) && !fifo_empty;
  assign out_fire     = bus.m_tvalid && bus.m_tready;
  assign out_last     = (out_cnt == beat_cnt - CNT_W'(1));
  assign bus.m_tlast  = out_last;
  assign bus.m_tdata  = fifo_dout[FW-1:BEAT_BYTES];
  assign bus.m_tkeep  = fifo_dout[BEAT_BYTES-1:0];

  assign bus.m_req_valid = req_valid_q;
  assign bus.m_req_vaddr = ptr;
  assign bus.m_req_len   = LEN_BITS'(byte_cnt);
  assign bus.m_req_pid   = pid_q;
  assign bus.m_req_last  = last_q;
  assign busy            = (state != ST_IDLE);

  dist_wr_fifo #(
    .WIDTH(FW),
    .DEPTH(MAX_BEATS)
  ) u_fifo (
    .clk    (aclk),
    .rst    (areset),
    .wr_en  (in_fire),
    .wr_data({bus.s_tdata, bus.s_tkeep}),
    .rd_en  (out_fire),
    .rd_data(fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // chunk sequencer: collect a chunk, announce it, then stream it out
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      pid_q       <= '0;
      beat_cnt    <= '0;
      out_cnt     <= '0;
      byte_cnt    <= '0;
      last_q      <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (restart) begin
            ptr   <= vaddr;
            pid_q <= pid;
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (in_fire) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            byte_cnt <= byte_cnt + keep_cnt;
          end
          if (chunk_end) begin
            last_q      <= bus.s_tlast;
            req_valid_q <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.m_req_ready) begin
            req_valid_q <= 1'b0;
            ptr         <= ptr + VADDR_BITS'(byte_cnt);
            out_cnt     <= '0;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            out_cnt <= out_cnt + CNT_W'(1);
            if (out_last) begin
              beat_cnt <= '0;
              byte_cnt <= '0;
              state    <= ST_FILL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dist_wr_gen.sv
// tb/tb_dist_wr_gen.sv - scoreboard bench for dist_wr_gen
module tb_dist_wr_gen;
  import lynxTypes::*;

  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
    logic [PID_BITS-1:0]   pid;
    logic                  last;
  } req_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic [VADDR_BITS-1:0] vaddr = '0;
  logic [PID_BITS-1:0]   pid = '0;
  logic                  restart = 1'b0;
  logic                  busy;

  dist_wr_gen_if #(.DATA_BITS(512)) bus ();

  dist_wr_gen #(.DATA_BITS(512), .MAX_BEATS(64)) dut (
    .aclk   (aclk),
    .areset (areset),
    .vaddr  (vaddr),
    .pid    (pid),
    .restart(restart),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int rmode = 0;
  int beats_seen = 0;

  req_t  exp_req[$];
  beat_t exp_beat[$];
  req_t  seen_req[$];

  // reference model state: chunking computed from the rules, not the RTL
  bit                    m_idle = 1'b1;
  logic [VADDR_BITS-1:0] m_ptr;
  logic [PID_BITS-1:0]   m_pid;
  int                    m_bytes;
  beat_t                 pend[$];

  task automatic chk(input string nm, input logic [639:0] got, input logic [639:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_idle = 1'b1;
    m_ptr = '0;
    m_pid = '0;
    m_bytes = 0;
    pend.delete();
    exp_req.delete();
    exp_beat.delete();
  endfunction

  function automatic void model_beat(logic [511:0] d, logic [63:0] k, bit l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = 1'b0;
    pend.push_back(b);
    m_bytes += $countones(k);
    if (l || pend.size() == 64) begin
      req_t r;
      r.vaddr = m_ptr;
      r.len   = LEN_BITS'(m_bytes);
      r.pid   = m_pid;
      r.last  = l;
      exp_req.push_back(r);
      m_ptr = m_ptr + VADDR_BITS'(m_bytes);
      pend[pend.size() - 1].last = 1'b1;
      foreach (pend[i]) exp_beat.push_back(pend[i]);
      pend.delete();
      m_bytes = 0;
    end
  endfunction

  // backpressure generator on the two output channels
  initial begin
    bus.m_req_ready = 1'b0;
    bus.m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0: begin bus.m_req_ready = 1'b1; bus.m_tready = 1'b1; end
        1: begin bus.m_req_ready = ($urandom_range(0, 2) != 0); bus.m_tready = ($urandom_range(0, 3) != 0); end
        2: begin bus.m_req_ready = 1'b0; bus.m_tready = 1'b1; end
        default: begin bus.m_req_ready = 1'b1; bus.m_tready = 1'b0; end
      endcase
    end
  end

  // monitor: pops the scoreboard whenever the DUT completes a handshake
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (bus.m_req_valid && bus.m_req_ready) begin
          req_t g;
          g = {bus.m_req_vaddr, bus.m_req_len, bus.m_req_pid, bus.m_req_last};
          seen_req.push_back(g);
          if (exp_req.size() == 0) chk("req_unexpected", g, '0);
          else chk("req", g, exp_req.pop_front());
        end
        if (bus.m_tvalid && bus.m_tready) begin
          beat_t g;
          g = {bus.m_tdata, bus.m_tkeep, bus.m_tlast};
          beats_seen++;
          if (exp_beat.size() == 0) chk("beat_unexpected", g, '0);
          else chk("beat", g, exp_beat.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // all tasks below start and end at posedge+1
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input bit l);
    int n;
    model_beat(d, k, l);
    bus.s_tvalid = 1'b1;
    bus.s_tdata = d;
    bus.s_tkeep = k;
    bus.s_tlast = l;
    n = 0;
    @(negedge aclk);
    while (!bus.s_tready && n < 3000) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 3000) chk("s_tready_timeout", 1, 0);
    @(posedge aclk);
    #1;
    bus.s_tvalid = 1'b0;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_keep();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r < 4) return {$urandom, $urandom};
    return '1;
  endfunction

  task automatic pulse_restart(input logic [VADDR_BITS-1:0] va, input logic [PID_BITS-1:0] p);
    if (m_idle) begin
      m_ptr = va;
      m_pid = p;
      m_idle = 1'b0;
    end
    vaddr = va;
    pid = p;
    restart = 1'b1;
    @(posedge aclk);
    #1;
    restart = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    bus.s_tvalid = 1'b0;
    restart = 1'b0;
    model_clear();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_beat.size() != 0) && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL drain_timeout got=%0d/%0d left exp=0", exp_req.size(), exp_beat.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_s_tready"}, bus.s_tready, 0);
    chk({nm, "_m_req_valid"}, bus.m_req_valid, 0);
    chk({nm, "_m_tvalid"}, bus.m_tvalid, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    int viol;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    bus.s_tkeep = '0;
    bus.s_tlast = 1'b0;
    model_clear();
    @(negedge aclk);
    check_idle_outputs("in_reset");
    @(posedge aclk);
    #1;
    do_reset();
    @(negedge aclk);
    check_idle_outputs("after_reset");
    @(posedge aclk);
    #1;

    // 64 full beats, no tlast: one 4 KB request
    rmode = 0;
    seen_req.delete();
    beats_seen = 0;
    pulse_restart(48'h1000, 6'd3);
    for (int i = 0; i < 64; i++) send_beat(rand_data(), '1, 1'b0);
    wait_drain();
    chk("t64_nreq", seen_req.size(), 1);
    chk("t64_nbeats", beats_seen, 64);
    if (seen_req.size() >= 1) chk("t64_req", seen_req[0], req_t'{48'h1000, 28'd4096, 6'd3, 1'b0});

    // 3 beats, partial keep on the tlast beat
    seen_req.delete();
    send_beat(rand_data(), '1, 1'b0);
    send_beat(rand_data(), '1, 1'b0);
    send_beat(rand_data(), 64'hFF, 1'b1);
    wait_drain();
    if (seen_req.size() >= 1) chk("t3_req", seen_req[0], req_t'{48'h2000, 28'd136, 6'd3, 1'b1});
    else chk("t3_nreq", seen_req.size(), 1);

    // empty-keep chunk still issues a zero-length request at the advanced pointer
    seen_req.delete();
    beats_seen = 0;
    send_beat(rand_data(), '0, 1'b1);
    wait_drain();
    chk("t0_nbeats", beats_seen, 1);
    if (seen_req.size() >= 1) chk("t0_req", seen_req[0], req_t'{48'h2088, 28'd0, 6'd3, 1'b1});
    else chk("t0_nreq", seen_req.size(), 1);

    // 70 beats with tlast on 70, restart attempt mid-fill must be ignored
    do_reset();
    seen_req.delete();
    pulse_restart(48'h1000, 6'd5);
    for (int i = 0; i < 70; i++) begin
      send_beat(rand_data(), '1, (i == 69));
      if (i == 10) pulse_restart(48'h8000, 6'd7);
    end
    wait_drain();
    chk("t70_nreq", seen_req.size(), 2);
    if (seen_req.size() >= 2) begin
      chk("t70_req0", seen_req[0], req_t'{48'h1000, 28'd4096, 6'd5, 1'b0});
      chk("t70_req1", seen_req[1], req_t'{48'h2000, 28'd384, 6'd5, 1'b1});
    end

    // request held off for 100 cycles
    rmode = 2;
    send_beat(rand_data(), rand_keep(), 1'b0);
    send_beat(rand_data(), rand_keep(), 1'b0);
    send_beat(rand_data(), rand_keep(), 1'b1);
    n = 0;
    while (!bus.m_req_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("hold_req_seen", bus.m_req_valid, 1);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.s_tready !== 1'b0 || bus.m_tvalid !== 1'b0 || bus.m_req_valid !== 1'b1) viol++;
      else if (exp_req.size() == 0) viol++;
      else if ({bus.m_req_vaddr, bus.m_req_len, bus.m_req_pid, bus.m_req_last} !== exp_req[0]) viol++;
    end
    chk("hold_violations", viol, 0);
    @(posedge aclk);
    #1;
    rmode = 1;
    wait_drain();

    // reset in the middle of draining
    rmode = 3;
    for (int i = 0; i < 4; i++) send_beat(rand_data(), '1, (i == 3));
    n = 0;
    while (!bus.m_tvalid && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_reached", bus.m_tvalid, 1);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    model_clear();
    @(negedge aclk);
    @(negedge aclk);
    check_idle_outputs("mid_drain_reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    rmode = 0;
    seen_req.delete();
    pulse_restart(48'h4000, 6'd9);
    send_beat(rand_data(), '1, 1'b0);
    send_beat(rand_data(), '1, 1'b1);
    wait_drain();
    if (seen_req.size() >= 1) chk("post_reset_req", seen_req[0], req_t'{48'h4000, 28'd128, 6'd9, 1'b1});
    else chk("post_reset_nreq", seen_req.size(), 1);

    // randomized streams under random backpressure
    do_reset();
    rmode = 1;
    pulse_restart({$urandom, $urandom}, 6'($urandom));
    for (int i = 0; i < 400; i++) begin
      send_beat(rand_data(), rand_keep(), ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      if ($urandom_range(0, 40) == 0) rmode = $urandom_range(0, 1);
    end
    send_beat(rand_data(), rand_keep(), 1'b1);
    rmode = 1;
    wait_drain();
    chk("rand_pending", pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dist_wr_gen.md
DIST_WR_GEN -- requirements
Module: dist_wr_gen

Interface
REQ-001 SHALL have parameter DATA_BITS, default 512, meaning data stream width in bits; beat size BEAT_BYTES = DATA_BITS/8.
REQ-002 SHALL have parameter MAX_BEATS, default 64, meaning maximum beats per chunk (4 KB at default).
REQ-003 SHALL have port aclk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port areset, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port vaddr, input, VADDR_BITS, meaning the base virtual address from the control register slave.
REQ-006 SHALL have port pid, input, PID_BITS, meaning the process ID from the control register slave.
REQ-007 SHALL have port restart, input, 1, meaning a one-cycle pulse that latches vaddr/pid and arms the block.
REQ-008 SHALL have ports s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast, directions in/out/in/in/in, widths 1/1/DATA_BITS/BEAT_BYTES/1, meaning the join-result input stream.
REQ-009 SHALL have ports m_req_valid/m_req_ready, directions out/in, width 1 each, meaning the write-request handshake.
REQ-010 SHALL have ports m_req_vaddr/m_req_len/m_req_pid/m_req_last, direction out, widths VADDR_BITS/LEN_BITS/PID_BITS/1, meaning the request fields.
REQ-011 SHALL have ports m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast, directions out/in/out/out/out, same widths as s_*, meaning the write data stream.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, REQ and DRAIN.
REQ-014 SHALL, in IDLE, hold s_tready=0 and on restart load ptr<=vaddr and pid_q<=pid, then enter FILL.
REQ-015 SHALL, in FILL, assert s_tready whenever the buffer is not full, writing each accepted beat to the buffer, incrementing beat_cnt, and adding popcount(s_tkeep) to byte_cnt.
REQ-016 SHALL close the chunk on the beat that makes beat_cnt == MAX_BEATS or that carries s_tlast=1, set last_q = s_tlast of that beat, and go to REQ next cycle; a tlast beat that is also beat MAX_BEATS closes one chunk only, with last_q=1.
REQ-017 SHALL, in REQ, hold s_tready=0 and m_req_valid=1 with vaddr=ptr, len=byte_cnt zero-extended to LEN_BITS, pid=pid_q and last=last_q, stable until m_req_ready.
REQ-018 SHALL, on the REQ handshake, set ptr <= ptr + byte_cnt (modulo 2^VADDR_BITS) and enter DRAIN.
REQ-019 SHALL, in DRAIN, present buffered beats on m_t* in order, assert m_tlast on beat number beat_cnt of the chunk, and hold s_tready=0.
REQ-020 SHALL, after the m_tlast handshake, clear beat_cnt and byte_cnt and return to FILL; ptr and pid_q persist across chunks and streams.
REQ-021 SHALL issue a request even when a closed chunk has byte_cnt=0 (all-zero tkeep), with len=0 and one data beat.
REQ-022 SHALL ignore restart outside IDLE.
REQ-023 SHALL add no bubble: the first data beat is valid in the cycle after the REQ handshake, and beat transfers run at one per cycle while m_tready=1.
REQ-024 SHALL never drop or duplicate a beat under any m_req_ready or m_tready backpressure pattern.

Reset
REQ-025 SHALL, on areset=1 (including mid-chunk), go to IDLE and clear ptr, pid_q, beat_cnt, byte_cnt, last_q, and the buffer pointers; buffered data is discarded.
REQ-026 SHALL drive these output values during and after reset: s_tready=0, m_req_valid=0, m_tvalid=0, busy=0; m_req_* and m_t* data fields are don't-care while their valid is low.

Structure
REQ-027 SHALL take VADDR_BITS, PID_BITS and LEN_BITS from the shared lynxTypes package and define no new package constants.
REQ-028 SHALL instantiate one sub-module, dist_wr_fifo: a synchronous FIFO of depth MAX_BEATS and width DATA_BITS+BEAT_BYTES, with full/empty flags.

Verification
REQ-029 SHALL cover: restart with vaddr=0x1000, pid=3, then 64 full beats without tlast -> one request (0x1000, 4096, 3, last=0) and 64 data beats with m_tlast on beat 64.
REQ-030 SHALL cover: 3 beats, the last with tkeep=0xFF and tlast -> request len=136, last=1; next ptr = base + 136.
REQ-031 SHALL cover: 70 full beats with tlast on beat 70 -> request (0x1000, 4096, last=0) then request (0x2000, 384, last=1).
REQ-032 SHALL cover: m_req_ready held low for 100 cycles -> s_tready stays 0, request fields are stable, no m_tvalid, and all beats are intact after release.
REQ-033 SHALL cover: areset pulsed mid-DRAIN -> next cycle all valids=0, busy=0; after a fresh restart, a new chunk starts at the new vaddr.
REQ-034 SHALL cover: restart pulsed during FILL with a different vaddr -> ignored, and the request uses the original base.
